fft_peak_detect_mc: RTL and testbench

- Parametrised successor to the single-channel FFT max-bin detector.
- Streams one FFT RAM word per clock with RD_LAT pipelining, instead of spending 4 cycles per bin.
- Finds the max-magnitude bin on a reference channel within a programmable bin window and above a threshold.
- Then fetches that bin's complex value from every channel, for downstream phase/direction estimation.

---
 rtl/fft_peak_detect_mc_if.sv | 28 ++
 rtl/fft_peak_detect_mc.sv | 197 +++++++++++++++++++
 tb/tb_fft_peak_detect_mc.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_detect_mc_if.sv
// Bundle between the multi-channel FFT peak detector and its FFT RAMs / controller.
// The slave modport is the detector's view; master is the controller and RAM side.
interface fft_peak_detect_mc_if #(
  parameter int NFFT_LOG2 = 10,
  parameter int W         = 14,
  parameter int NCH       = 4
);
  logic                   start;
  logic [2*W-1:0]         thresh;
  logic [NCH*2*W-1:0]     ramq;
  logic [NFFT_LOG2-1:0]   ramaddr;
  logic                   busy;
  logic                   done;
  logic                   found;
  logic [NFFT_LOG2-1:0]   maxbin;
  logic [2*W-1:0]         maxmag;
  logic [NCH*2*W-1:0]     peak_data;

  modport master (
    output start, thresh, ramq,
    input  ramaddr, busy, done, found, maxbin, maxmag, peak_data
  );

  modport slave (
    input  start, thresh, ramq,
    output ramaddr, busy, done, found, maxbin, maxmag, peak_data
  );
endinterface

// File: rtl/fft_peak_detect_mc.sv
// Streams every FFT bin once, tracks the windowed max-magnitude bin on REF_CH, then fetches all channels at it.
// Optional macro MAG_L1_EN: use |re|+|im| instead of re^2+im^2 as the magnitude metric.
module fft_peak_detect_mc #(
  parameter int NFFT_LOG2 = 10,
  parameter int W         = 14,
  parameter int NCH       = 4,
  parameter int REF_CH    = 0,
  parameter int BIN_LO    = 31,
  parameter int BIN_HI    = 1023,
  parameter int RD_LAT    = 2,
  parameter int BITREV    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_peak_detect_mc_if.slave  bus
);
  localparam int N  = 1 << NFFT_LOG2;
  localparam int MW = 2 * W;
  localparam int CW = $clog2(RD_LAT + 2);
  localparam int DW = NCH * MW;

  typedef logic [NFFT_LOG2-1:0] addr_t;
  typedef logic [MW-1:0]        mag_t;
  typedef logic [CW-1:0]        cnt_t;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, FETCH, DONE} state_t;

  if (!(BIN_LO >= 0 && BIN_LO <= BIN_HI && BIN_HI < N)) begin : g_bad_window
    $error("fft_peak_detect_mc: BIN_LO/BIN_HI window outside 0..N-1");
  end
  if (!(REF_CH >= 0 && REF_CH < NCH)) begin : g_bad_ref
    $error("fft_peak_detect_mc: REF_CH must be below NCH");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("fft_peak_detect_mc: RD_LAT must be at least 1");
  end

  function automatic addr_t bin_of(addr_t a);
    addr_t r;
    if (BITREV != 0) begin
      for (int i = 0; i < NFFT_LOG2; i++) r[i] = a[NFFT_LOG2-1-i];
    end else begin
      r = a;
    end
    return r;
  endfunction

  state_t          state_q, state_n;
  logic            start_q;
  cnt_t            cnt_q;
  addr_t           ramaddr_q;
  logic [RD_LAT-1:0] vld_pipe;
  addr_t           addr_pipe [RD_LAT];
  mag_t            best_mag;
  addr_t           best_addr;
  logic            best_hit;
  logic [DW-1:0]   peak_r;

  logic            busy_q, done_q, found_q;
  addr_t           maxbin_q;
  mag_t            maxmag_q;
  logic [DW-1:0]   peak_data_q;

  // Reference-channel magnitude of the word returning from the pipeline tail.
  logic signed [W-1:0] re, im;
  mag_t                mag;
  addr_t               tail_addr, tail_bin, addr_n;
  logic                tail_vld, in_window, upd, hit_n;

  assign re = bus.ramq[REF_CH*MW + W +: W];
  assign im = bus.ramq[REF_CH*MW     +: W];

`ifdef MAG_L1_EN
  logic [W:0] abs_re, abs_im;
  assign abs_re = re[W-1] ? (~{re[W-1], re} + (W+1)'(1)) : {1'b0, re};
  assign abs_im = im[W-1] ? (~{im[W-1], im} + (W+1)'(1)) : {1'b0, im};
  assign mag    = {{(MW-W-1){1'b0}}, abs_re + abs_im};
`else
  logic signed [MW-1:0] re_x, im_x, re2, im2;
  assign re_x = {{W{re[W-1]}}, re};
  assign im_x = {{W{im[W-1]}}, im};
  assign re2  = re_x * re_x;
  assign im2  = im_x * im_x;
  assign mag  = mag_t'(re2) + mag_t'(im2);
`endif

  assign tail_vld  = vld_pipe[RD_LAT-1];
  assign tail_addr = addr_pipe[RD_LAT-1];
  assign tail_bin  = bin_of(tail_addr);
  assign in_window = (int'(tail_bin) >= BIN_LO) && (int'(tail_bin) <= BIN_HI);
  // Strict compare keeps the earliest-scanned address on ties and rejects mag == threshold.
  assign upd       = tail_vld && in_window && (mag > best_mag);
  assign hit_n     = best_hit | upd;
  assign addr_n    = upd ? tail_addr : best_addr;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_n = state_q;
    unique case (state_q)
      IDLE:  if (bus.start && !start_q)            state_n = SCAN;
      SCAN:  if (ramaddr_q == addr_t'(N-1))        state_n = DRAIN;
      DRAIN: if (cnt_q == cnt_t'(RD_LAT-1))        state_n = hit_n ? FETCH : DONE;
      FETCH: if (cnt_q == cnt_t'(RD_LAT))          state_n = DONE;
      DONE:                                         state_n = IDLE;
      default:                                      state_n = IDLE;
    endcase
  end

  // Output / control decode
  logic launch, scan_vld, fetch_latch, finish;
  always_comb begin
    launch      = 1'b0;
    scan_vld    = 1'b0;
    fetch_latch = 1'b0;
    finish      = 1'b0;
    unique case (state_q)
      IDLE:    launch      = bus.start && !start_q;
      SCAN:    scan_vld    = 1'b1;
      FETCH:   fetch_latch = (cnt_q == cnt_t'(RD_LAT));
      DONE:    finish      = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address generation, read-tracking pipeline, running max, result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the short tracking pipeline is reset too, so a mid-scan reset can never replay stale valids.
      start_q     <= 1'b0;
      cnt_q       <= '0;
      ramaddr_q   <= '0;
      vld_pipe    <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
      best_mag    <= '0;
      best_addr   <= '0;
      best_hit    <= 1'b0;
      peak_r      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      maxbin_q    <= '0;
      maxmag_q    <= '0;
      peak_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (state_q == IDLE) start_q <= bus.start;
      cnt_q <= (state_n != state_q) ? '0 : cnt_q + cnt_t'(1);

      vld_pipe[0]  <= scan_vld;
      addr_pipe[0] <= ramaddr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end

      if (launch)                                       ramaddr_q <= '0;
      else if (state_q == SCAN && state_n == SCAN)      ramaddr_q <= ramaddr_q + addr_t'(1);
      else if (state_q == DRAIN && state_n == FETCH)    ramaddr_q <= addr_n;

      if (launch) begin
        best_mag  <= bus.thresh;
        best_addr <= '0;
        best_hit  <= 1'b0;
      end else if (upd) begin
        best_mag  <= mag;
        best_addr <= tail_addr;
        best_hit  <= 1'b1;
      end

      if (fetch_latch) peak_r <= bus.ramq;

      done_q <= finish;
      if (launch) busy_q <= 1'b1;
      if (finish) begin
        busy_q      <= 1'b0;
        found_q     <= best_hit;
        maxbin_q    <= best_hit ? bin_of(best_addr) : '0;
        maxmag_q    <= best_hit ? best_mag : '0;
        peak_data_q <= best_hit ? peak_r : '0;
      end
    end
  end

  assign bus.ramaddr   = ramaddr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.maxbin    = maxbin_q;
  assign bus.maxmag    = maxmag_q;
  assign bus.peak_data = peak_data_q;
endmodule

// File: tb/tb_fft_peak_detect_mc.sv
// Directed bench for fft_peak_detect_mc: a linear-order and a bit-reversed instance share one RAM image.
module tb_fft_peak_detect_mc;
  localparam int NFFT_LOG2 = 10;
  localparam int W         = 14;
  localparam int NCH       = 4;
  localparam int N         = 1 << NFFT_LOG2;
  localparam int DW        = NCH * 2 * W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_peak_detect_mc_if #(.NFFT_LOG2(NFFT_LOG2), .W(W), .NCH(NCH)) bl ();
  fft_peak_detect_mc_if #(.NFFT_LOG2(NFFT_LOG2), .W(W), .NCH(NCH)) br ();

  fft_peak_detect_mc #(.NFFT_LOG2(NFFT_LOG2), .W(W), .NCH(NCH), .REF_CH(0),
                       .BIN_LO(31), .BIN_HI(1023), .RD_LAT(2), .BITREV(0))
    u_lin (.clk(clk), .reset(reset), .bus(bl));

  fft_peak_detect_mc #(.NFFT_LOG2(NFFT_LOG2), .W(W), .NCH(NCH), .REF_CH(0),
                       .BIN_LO(31), .BIN_HI(1023), .RD_LAT(2), .BITREV(1))
    u_rev (.clk(clk), .reset(reset), .bus(br));

  logic [2*W-1:0] mem [NCH][N];
  logic [DW-1:0]  rl1, rr1;

  function automatic logic [DW-1:0] word_at(int a);
    logic [DW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*2*W +: 2*W] = mem[c][a];
    return v;
  endfunction

  // Two-stage registered RAM read per instance (RD_LAT = 2).
  always @(posedge clk) begin
    rl1     <= word_at(int'(bl.ramaddr));
    bl.ramq <= rl1;
    rr1     <= word_at(int'(br.ramaddr));
    br.ramq <= rr1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint exp_mag(int re, int im);
`ifdef MAG_L1_EN
    return longint'((re < 0) ? -re : re) + longint'((im < 0) ? -im : im);
`else
    return longint'(re) * longint'(re) + longint'(im) * longint'(im);
`endif
  endfunction

  task automatic fill_base();
    for (int a = 0; a < N; a++) begin
      mem[0][a] = {W'(1), W'(1)};
      for (int c = 1; c < NCH; c++) mem[c][a] = {W'(c * 256 + a % 256), W'(a)};
    end
  endtask

  task automatic set_ref(input int a, input int re, input int im);
    mem[0][a] = {W'(re), W'(im)};
  endtask

  // Raise start, then observe a fixed window counting busy cycles and done pulses.
  task automatic run(input bit rev, input bit toggle, output int cyc, output int nd);
    cyc = 0;
    nd  = 0;
    @(negedge clk);
    if (rev) br.start = 1'b1; else bl.start = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (rev ? br.busy : bl.busy) cyc++;
      if (rev ? br.done : bl.done) nd++;
      if (toggle && (i == 200 || i == 400)) bl.start = 1'b0;
      if (toggle && (i == 201 || i == 403)) bl.start = 1'b1;
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    bl.start = 1'b0;
    br.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_lin(input string tag, input logic f, input int bin, input longint m,
                           input logic [DW-1:0] pd);
    check({tag, "_found"}, 128'(bl.found), 128'(f));
    check({tag, "_maxbin"}, 128'(bl.maxbin), 128'(bin));
    check({tag, "_maxmag"}, 128'(bl.maxmag), 128'(m));
    check({tag, "_peak"}, 128'(bl.peak_data), 128'(pd));
  endtask

  int cyc, nd;
  localparam longint PEAK = (300 * 300 + 400 * 400);

  initial begin
    bl.start = 1'b0; bl.thresh = '0;
    br.start = 1'b0; br.thresh = '0;
    fill_base();
    repeat (3) @(negedge clk);
    check("rst_ramaddr", 128'(bl.ramaddr), 0);
    check("rst_busy", 128'(bl.busy), 0);
    check("rst_done", 128'(bl.done), 0);
    check("rst_found", 128'(bl.found), 0);
    check("rst_maxbin", 128'(bl.maxbin), 0);
    check("rst_maxmag", 128'(bl.maxmag), 0);
    check("rst_peak", 128'(bl.peak_data), 0);
    reset = 1'b0;

    // Single peak, linear order.
    set_ref(100, 300, 400);
    run(1'b0, 1'b0, cyc, nd);
    check("t1_busy_cycles", 128'(cyc), 1030);
    check("t1_done_count", 128'(nd), 1);
    check_lin("t1", 1'b1, 100, exp_mag(300, 400), word_at(100));
    release_start();

    // Bit-reversed storage: address 0x026 holds bin 0x190.
    fill_base();
    set_ref('h026, 300, 400);
    run(1'b1, 1'b0, cyc, nd);
    check("t2_busy_cycles", 128'(cyc), 1030);
    check("t2_done_count", 128'(nd), 1);
    check("t2_found", 128'(br.found), 1);
    check("t2_maxbin", 128'(br.maxbin), 'h190);
    check("t2_maxmag", 128'(br.maxmag), 128'(exp_mag(300, 400)));
    check("t2_peak", 128'(br.peak_data), 128'(word_at('h026)));
    release_start();

    // Largest value below BIN_LO is ignored.
    fill_base();
    set_ref(5, 1000, 1000);
    set_ref(40, 500, 500);
    run(1'b0, 1'b0, cyc, nd);
    check_lin("t3", 1'b1, 40, exp_mag(500, 500), word_at(40));
    release_start();

    // Equal maxima: earliest scanned wins.
    fill_base();
    set_ref(60, 300, 400);
    set_ref(70, 400, 300);
    run(1'b0, 1'b0, cyc, nd);
    check_lin("t4", 1'b1, 60, exp_mag(300, 400), word_at(60));
    release_start();

    // Window edges are inclusive.
    fill_base();
    set_ref(30, 1000, 0);
    set_ref(31, 10, 0);
    run(1'b0, 1'b0, cyc, nd);
    check_lin("t5_lo", 1'b1, 31, exp_mag(10, 0), word_at(31));
    release_start();

    fill_base();
    set_ref(1023, 20, 0);
    run(1'b0, 1'b0, cyc, nd);
    check_lin("t6_hi", 1'b1, 1023, exp_mag(20, 0), word_at(1023));
    release_start();

    // Peak exactly at threshold does not qualify.
    fill_base();
    set_ref(100, 300, 400);
    bl.thresh = (2*W)'(exp_mag(300, 400));
    run(1'b0, 1'b0, cyc, nd);
    check("t7_busy_cycles", 128'(cyc), 1027);
    check("t7_done_count", 128'(nd), 1);
    check_lin("t7", 1'b0, 0, 0, '0);
    release_start();

    // Most negative components, no overflow.
    bl.thresh = '0;
    fill_base();
    set_ref(200, -8192, -8192);
    run(1'b0, 1'b0, cyc, nd);
`ifdef MAG_L1_EN
    check_lin("t8", 1'b1, 200, 16384, word_at(200));
`else
    check_lin("t8", 1'b1, 200, 134217728, word_at(200));
`endif
    release_start();

    // Reset in the middle of SCAN aborts at once and produces no done.
    @(negedge clk);
    bl.start = 1'b1;
    repeat (501) @(negedge clk);
    check("t9_busy_before_reset", 128'(bl.busy), 1);
    reset = 1'b1;
    #1;
    check("t9_busy", 128'(bl.busy), 0);
    check("t9_ramaddr", 128'(bl.ramaddr), 0);
    check("t9_done", 128'(bl.done), 0);
    check_lin("t9", 1'b0, 0, 0, '0);
    bl.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    nd  = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (bl.busy) cyc++;
      if (bl.done) nd++;
    end
    check("t9_no_busy_after", 128'(cyc), 0);
    check("t9_no_done_after", 128'(nd), 0);

    // start held high does not relaunch; a fresh edge does; edges during SCAN are ignored.
    fill_base();
    set_ref(300, 300, 400);
    run(1'b0, 1'b0, cyc, nd);
    check_lin("t10", 1'b1, 300, exp_mag(300, 400), word_at(300));
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bl.busy || bl.done) cyc++;
    end
    check("t10_held_no_launch", 128'(cyc), 0);
    release_start();
    set_ref(300, 1, 1);
    set_ref(500, 300, 400);
    run(1'b0, 1'b1, cyc, nd);
    check("t11_busy_cycles", 128'(cyc), 1030);
    check("t11_done_count", 128'(nd), 1);
    check_lin("t11", 1'b1, 500, exp_mag(300, 400), word_at(500));
    release_start();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
